// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP payload buffer.
package udp_pkg;

   // Transmit-side sequencer states.
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_WAIT  = 2'd2
   } tx_state_t;

   // Occupancy flag of one RAM bank.
   localparam logic BANK_EMPTY = 1'b0;
   localparam logic BANK_FULL  = 1'b1;

   // Metadata kept per bank while it is filled and until it is sent.
   typedef struct packed {
      logic [15:0] length;
      logic [31:0] csum;
      logic [31:0] time_stamp;
      logic [7:0]  channel;
   } frame_meta_t;

   // Contribution of one sample word to the partial checksum (no carry fold).
   function automatic logic [31:0] word_sum(input logic [31:0] w);
      return 32'(w[31:16]) + 32'(w[15:0]);
   endfunction

endpackage

// File: rtl/udp_bank_ram.sv
// Two-bank simple dual-port RAM; bank select is the address MSB.
module udp_bank_ram #(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W:0]   wr_addr,
   input  logic [31:0]       wr_data,
   input  logic [ADDR_W:0]   rd_addr,
   output logic [31:0]       rd_data
);

   logic [31:0] mem [0:(2**(ADDR_W+1))-1];

   // Write port.
   // NOTE: the storage array has no reset; a RAM cannot be cleared in one cycle and
   // every location is written before it is read, so only the read register is reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read port, one cycle of latency.
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/udp_payload_buffer.sv
// Ping-pong payload buffer feeding udp_sender: fills one bank while the other is sent.
module udp_payload_buffer
   import udp_pkg::*;
#(
   parameter int          MAX_WORDS  = 256,
   parameter int          ADDR_W     = 11,
   parameter int unsigned IDLE_FLUSH = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   input  logic [31:0]       time_now,
   input  logic [7:0]        ch_id,
   output logic              en,
   output logic [15:0]       mem_length,
   output logic [31:0]       crc_data,
   output logic [31:0]       time_buf,
   output logic [7:0]        channel,
   input  logic [ADDR_W-1:0] mem_adr_rd,
   output logic [31:0]       mem_data,
   input  logic              END_TX,
   output logic [15:0]       drop_cnt
);

   localparam logic [ADDR_W-1:0] MAX_CNT   = ADDR_W'(MAX_WORDS);
   localparam logic [31:0]       FLUSH_LIM = 32'(IDLE_FLUSH);
   localparam bit                FLUSH_EN  = (IDLE_FLUSH != 0);

   logic [1:0]        bank_state;
   logic [1:0]        bank_next;
   logic              wr_bank;
   logic              wr_bank_next;
   logic              rd_bank;
   logic [ADDR_W-1:0] wr_count;
   logic [ADDR_W-1:0] count_inc;
   logic [ADDR_W-1:0] close_count;
   logic [31:0]       idle_cnt;
   logic [31:0]       word_add;
   frame_meta_t       meta [2];
   tx_state_t         tx_state;
   tx_state_t         tx_next;

   logic accept;
   logic close_on_word;
   logic flush;
   logic close_frame;
   logic release_rd;
   logic load_meta;

   assign accept        = s_valid & s_ready;
   assign count_inc     = wr_count + ADDR_W'(1);
   assign close_count   = accept ? count_inc : wr_count;
   assign close_on_word = accept & ((count_inc == MAX_CNT) | s_last);
   // The flush close fires on the edge where the idle count would reach the limit.
   assign flush         = FLUSH_EN && !accept && (wr_count != '0)
                          && ((idle_cnt + 32'd1) >= FLUSH_LIM);
   assign close_frame   = close_on_word | flush;
   assign release_rd    = (tx_state == TX_WAIT) & END_TX;
   assign load_meta     = (tx_state == TX_IDLE) & (bank_state[rd_bank] == BANK_FULL);
   assign word_add      = word_sum(s_data);

   // Word i of a frame lands at address i+1; address 0 stays unused.
   udp_bank_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (accept),
      .wr_addr ({wr_bank, count_inc}),
      .wr_data (s_data),
      .rd_addr ({rd_bank, mem_adr_rd}),
      .rd_data (mem_data)
   );

   // Next bank occupancy: a close and a release of the other bank may coincide.
   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      bank_next    = bank_state;
      wr_bank_next = wr_bank;
      if (close_frame) begin
         bank_next[wr_bank] = BANK_FULL;
         wr_bank_next       = ~wr_bank;
      end
      if (release_rd) begin
         bank_next[rd_bank] = BANK_EMPTY;
      end
   end

   // Bank flags, write bank pointer and s_ready (registered from next-state values).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_state <= {BANK_EMPTY, BANK_EMPTY};
         wr_bank    <= 1'b0;
         s_ready    <= 1'b0;
      end else begin
         bank_state <= bank_next;
         wr_bank    <= wr_bank_next;
         s_ready    <= (bank_next[wr_bank_next] == BANK_EMPTY);
      end
   end

   // Word counter of the open frame and idle-cycle counter for the flush close.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_count <= '0;
         idle_cnt <= '0;
      end else if (close_frame) begin
         wr_count <= '0;
         idle_cnt <= '0;
      end else if (accept) begin
         wr_count <= count_inc;
         idle_cnt <= '0;
      end else if (wr_count != '0) begin
         idle_cnt <= idle_cnt + 32'd1;
      end
   end

   // Per-bank metadata: first-word timestamp/channel, running sum, length at close.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            meta[b] <= '0;
         end
      end else begin
         if (accept) begin
            if (wr_count == '0) begin
               meta[wr_bank].csum       <= word_add;
               meta[wr_bank].time_stamp <= time_now;
               meta[wr_bank].channel    <= ch_id;
            end else begin
               meta[wr_bank].csum <= meta[wr_bank].csum + word_add;
            end
         end
         if (close_frame) begin
            meta[wr_bank].length <= 16'({close_count, 2'b00});
         end
      end
   end

   // Saturating count of words offered while the buffer was not ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (s_valid && !s_ready && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end

   // TX state register, read bank pointer and metadata outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state   <= TX_IDLE;
         rd_bank    <= 1'b0;
         mem_length <= '0;
         crc_data   <= '0;
         time_buf   <= '0;
         channel    <= '0;
      end else begin
         tx_state <= tx_next;
         if (release_rd) begin
            rd_bank <= ~rd_bank;
         end
         if (load_meta) begin
            mem_length <= meta[rd_bank].length;
            crc_data   <= meta[rd_bank].csum;
            time_buf   <= meta[rd_bank].time_stamp;
            channel    <= meta[rd_bank].channel;
         end
      end
   end

   // TX next state and the one-cycle start pulse.
   always_comb begin
      tx_next = tx_state;
      en      = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (bank_state[rd_bank] == BANK_FULL) begin
               tx_next = TX_START;
            end
         end
         TX_START: begin
            en      = 1'b1;
            tx_next = TX_WAIT;
         end
         TX_WAIT: begin
            if (END_TX) begin
               tx_next = TX_IDLE;
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_udp_payload_buffer.sv
// Self-checking bench for udp_payload_buffer against a frame-level reference model.
module tb_udp_payload_buffer;

   localparam int MAX_WORDS  = 256;
   localparam int ADDR_W     = 11;
   localparam int IDLE_FLUSH = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [31:0]       s_data = '0;
   logic              s_valid = 1'b0;
   logic              s_last = 1'b0;
   logic              s_ready;
   logic [31:0]       time_now = '0;
   logic [7:0]        ch_id = '0;
   logic              en;
   logic [15:0]       mem_length;
   logic [31:0]       crc_data;
   logic [31:0]       time_buf;
   logic [7:0]        channel;
   logic [ADDR_W-1:0] mem_adr_rd = '0;
   logic [31:0]       mem_data;
   logic              END_TX = 1'b0;
   logic [15:0]       drop_cnt;

   udp_payload_buffer #(
      .MAX_WORDS  (MAX_WORDS),
      .ADDR_W     (ADDR_W),
      .IDLE_FLUSH (IDLE_FLUSH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_last     (s_last),
      .s_ready    (s_ready),
      .time_now   (time_now),
      .ch_id      (ch_id),
      .en         (en),
      .mem_length (mem_length),
      .crc_data   (crc_data),
      .time_buf   (time_buf),
      .channel    (channel),
      .mem_adr_rd (mem_adr_rd),
      .mem_data   (mem_data),
      .END_TX     (END_TX),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] len;
      logic [31:0] sum;
      logic [31:0] ts;
      logic [7:0]  ch;
   } meta_t;

   // Reference model: frames closed but not yet released, in send order.
   meta_t       exp_q[$];
   logic [31:0] data_q[$];
   logic [31:0] cur_data[$];
   logic [31:0] cur_sum = '0;
   logic [31:0] cur_ts = '0;
   logic [7:0]  cur_ch = '0;
   int          idle = 0;
   int          pending = 0;
   bit          tx_active = 1'b0;
   int          drops = 0;
   int          exp_en = 0;

   // Captured start pulses with the metadata present during them.
   meta_t got_q[$];
   int    en_cnt = 0;

   int n_checks = 0;
   int n_fail = 0;

   always @(negedge clk) begin
      if (en === 1'b1) begin
         meta_t m;
         m.len = mem_length;
         m.sum = crc_data;
         m.ts  = time_buf;
         m.ch  = channel;
         got_q.push_back(m);
         en_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_ready();
      return pending < 2;
   endfunction

   task automatic model_close();
      meta_t m;
      m.len = 16'(cur_data.size() * 4);
      m.sum = cur_sum;
      m.ts  = cur_ts;
      m.ch  = cur_ch;
      exp_q.push_back(m);
      foreach (cur_data[i]) data_q.push_back(cur_data[i]);
      cur_data.delete();
      cur_sum = '0;
      idle = 0;
      pending++;
      exp_en++;
   endtask

   task automatic model_reset();
      exp_q.delete();
      data_q.delete();
      cur_data.delete();
      got_q.delete();
      cur_sum = '0;
      idle = 0;
      pending = 0;
      tx_active = 1'b0;
      drops = 0;
   endtask

   // Apply the current inputs to the model for the coming edge, then advance one clock.
   task automatic tick();
      bit acc;
      acc = s_valid && m_ready() && rst_n;
      if (rst_n && END_TX && tx_active) begin
         meta_t m;
         m = exp_q.pop_front();
         for (int k = 0; k < int'(m.len) / 4; k++) void'(data_q.pop_front());
         pending--;
         tx_active = 1'b0;
      end
      if (acc) begin
         if (cur_data.size() == 0) begin
            cur_ts  = time_now;
            cur_ch  = ch_id;
            cur_sum = '0;
         end
         cur_sum = cur_sum + 32'(s_data[31:16]) + 32'(s_data[15:0]);
         cur_data.push_back(s_data);
         idle = 0;
         if (cur_data.size() == MAX_WORDS || s_last) model_close();
      end else if (rst_n) begin
         if (s_valid && drops < 65535) drops++;
         if (cur_data.size() > 0) begin
            idle++;
            if (idle == IDLE_FLUSH) model_close();
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input bit last, input logic [31:0] ts,
                       input logic [7:0] ch, input bit etx);
      check("s_ready", 32'(s_ready), 32'(m_ready()));
      s_valid  = 1'b1;
      s_data   = d;
      s_last   = last;
      time_now = ts;
      ch_id    = ch;
      END_TX   = etx;
      tick();
      s_valid  = 1'b0;
      s_last   = 1'b0;
      END_TX   = 1'b0;
   endtask

   task automatic expect_tx(input string tag, input int max_wait, output int waited);
      meta_t g;
      meta_t e;
      waited = 0;
      while (got_q.size() == 0 && waited < max_wait) begin
         tick();
         waited++;
      end
      check({tag, ".en_pulses"}, 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q[0];
         check({tag, ".mem_length"}, 32'(g.len), 32'(e.len));
         check({tag, ".crc_data"},   g.sum,      e.sum);
         check({tag, ".time_buf"},   g.ts,       e.ts);
         check({tag, ".channel"},    32'(g.ch),  32'(e.ch));
         tx_active = 1'b1;
      end
   endtask

   task automatic read_frame(input string tag);
      if (exp_q.size() > 0) begin
         for (int i = 0; i < int'(exp_q[0].len) / 4; i++) begin
            mem_adr_rd = ADDR_W'(i + 1);
            tick();
            check({tag, ".mem_data"}, mem_data, data_q[i]);
         end
      end
      mem_adr_rd = '0;
   endtask

   task automatic end_tx(input string tag);
      if (exp_q.size() > 0) begin
         check({tag, ".hold_length"}, 32'(mem_length), 32'(exp_q[0].len));
         check({tag, ".hold_crc"},    crc_data,        exp_q[0].sum);
      end
      END_TX = 1'b1;
      tick();
      END_TX = 1'b0;
   endtask

   initial begin
      int w;
      int n;

      // Reset state.
      repeat (3) tick();
      check("rst.en",         32'(en),         32'd0);
      check("rst.s_ready",    32'(s_ready),    32'd0);
      check("rst.mem_length", 32'(mem_length), 32'd0);
      check("rst.crc_data",   crc_data,        32'd0);
      check("rst.time_buf",   time_buf,        32'd0);
      check("rst.channel",    32'(channel),    32'd0);
      check("rst.mem_data",   mem_data,        32'd0);
      check("rst.drop_cnt",   32'(drop_cnt),   32'd0);
      rst_n = 1'b1;
      check("rel.s_ready_low", 32'(s_ready), 32'd0);
      tick();
      check("rel.s_ready_high", 32'(s_ready), 32'd1);

      // Full frame of identical words, closed by the word count.
      for (int i = 0; i < MAX_WORDS; i++) send(32'h0001_0002, 1'b0, $urandom, 8'($urandom), 1'b0);
      expect_tx("full", 10, w);
      check("full.len_const", 32'(mem_length), 32'd1024);
      check("full.crc_const", crc_data,        32'h0000_0300);
      read_frame("full");
      end_tx("full");

      // Short frame closed by s_last; metadata from the first word.
      send($urandom, 1'b0, 32'h0000_1234, 8'd5, 1'b0);
      send($urandom, 1'b0, $urandom, 8'($urandom), 1'b0);
      send($urandom, 1'b1, $urandom, 8'($urandom), 1'b0);
      expect_tx("last3", 10, w);
      check("last3.len_const", 32'(mem_length), 32'd12);
      check("last3.ts_const",  time_buf,         32'h0000_1234);
      check("last3.ch_const",  32'(channel),     32'd5);
      read_frame("last3");
      end_tx("last3");

      // Random frames with short gaps.
      for (int f = 0; f < 4; f++) begin
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) begin
            send($urandom, (i == n - 1), $urandom, 8'($urandom), 1'b0);
            repeat ($urandom_range(0, 3)) tick();
         end
         expect_tx("rand", 10, w);
         read_frame("rand");
         repeat ($urandom_range(0, 3)) tick();
         end_tx("rand");
      end

      // Back-pressure: two frames held, extra words dropped, one release reopens.
      for (int i = 0; i < 2 * MAX_WORDS; i++) send($urandom, 1'b0, $urandom, 8'($urandom), 1'b0);
      for (int i = 0; i < 5; i++) send($urandom, 1'b0, $urandom, 8'($urandom), 1'b0);
      check("bp.drop_cnt",       32'(drop_cnt), 32'(drops));
      check("bp.drop_cnt_const", 32'(drop_cnt), 32'd5);
      expect_tx("bp.a", 10, w);
      check("bp.s_ready_low", 32'(s_ready), 32'(m_ready()));
      end_tx("bp.a");
      check("bp.s_ready_back", 32'(s_ready), 32'd1);
      expect_tx("bp.b", 10, w);
      end_tx("bp.b");

      // Idle flush: one word, then silence.
      send($urandom, 1'b0, $urandom, 8'($urandom), 1'b0);
      expect_tx("flush", 40, w);
      check("flush.latency_ok", 32'(w >= IDLE_FLUSH && w <= IDLE_FLUSH + 4), 32'd1);
      check("flush.len_const",  32'(mem_length), 32'd4);
      read_frame("flush");
      end_tx("flush");

      // Release of one bank in the same cycle as the close of the other.
      send($urandom, 1'b0, $urandom, 8'($urandom), 1'b0);
      send($urandom, 1'b1, $urandom, 8'($urandom), 1'b0);
      expect_tx("sim.p", 10, w);
      send($urandom, 1'b0, $urandom, 8'($urandom), 1'b0);
      send($urandom, 1'b0, $urandom, 8'($urandom), 1'b0);
      send($urandom, 1'b1, $urandom, 8'($urandom), 1'b1);
      check("sim.s_ready", 32'(s_ready), 32'(m_ready()));
      expect_tx("sim.q", 6, w);
      check("sim.q_within_3", 32'(w <= 3), 32'd1);
      read_frame("sim.q");
      end_tx("sim.q");

      // Reset while waiting for END_TX, with a partial frame in the other bank.
      send($urandom, 1'b0, $urandom, 8'($urandom), 1'b0);
      send($urandom, 1'b1, $urandom, 8'($urandom), 1'b0);
      expect_tx("rstw", 10, w);
      for (int i = 0; i < 3; i++) send($urandom, 1'b0, $urandom, 8'($urandom), 1'b0);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rstw.en",         32'(en),         32'd0);
      check("rstw.s_ready",    32'(s_ready),    32'd0);
      check("rstw.mem_length", 32'(mem_length), 32'd0);
      check("rstw.drop_cnt",   32'(drop_cnt),   32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      END_TX = 1'b1;
      tick();
      END_TX = 1'b0;
      check("rstw.s_ready_after", 32'(s_ready), 32'd1);
      repeat (4) tick();
      check("rstw.no_en", 32'(got_q.size()), 32'd0);
      for (int f = 0; f < 3; f++) begin
         send($urandom, 1'b0, $urandom, 8'($urandom), 1'b0);
         send($urandom, 1'b1, $urandom, 8'($urandom), 1'b0);
         expect_tx("post", 10, w);
         check("post.len_const", 32'(mem_length), 32'd8);
         read_frame("post");
         end_tx("post");
      end

      repeat (4) tick();
      check("end.en_count", 32'(en_cnt), 32'(exp_en));
      check("end.leftover", 32'(got_q.size()), 32'd0);
      check("end.s_ready",  32'(s_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
